// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the knight-move command path: command opcodes, the
// bit positions of the fields inside a 16-bit command word, the response bytes
// TourCmd sends back to the host, and the heading expansion helper.
// -----------------------------------------------------------------------------
package cmd_pkg;

   // Command opcodes carried in cmd[15:12]; anything else is a no-op.
   typedef enum logic [3:0] {
      CAL      = 4'h0,
      MOVE     = 4'h2,
      MOVE_FAN = 4'h3
   } opcode_e;

   // Field positions inside the 16-bit command word.
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int HDG_MSB = 11;
   localparam int HDG_LSB = 4;
   localparam int SQ_MSB  = 3;
   localparam int SQ_LSB  = 0;

   // Response bytes used by TourCmd toward the host.
   localparam logic [7:0] RESP_ACK  = 8'hA5;
   localparam logic [7:0] RESP_DONE = 8'h5A;

   // An 8-bit heading field expands to a 12-bit PID heading. Non-zero headings
   // get the low nibble filled with F so the target sits mid-bucket; zero
   // (due north) stays exactly zero.
   function automatic logic [11:0] heading_of(input logic [7:0] hdg);
      return (hdg != 8'h00) ? {hdg, 4'hF} : 12'h000;
   endfunction

endpackage

// File: rtl/cmd_exec_frwrd_ramp.sv
// -----------------------------------------------------------------------------
// frwrd_ramp
// Saturating forward-speed ramp register. Steps up by FRWRD_INC per clock
// (clamped at FRWRD_MAX) or down by 2*FRWRD_INC per clock (clamped at 0).
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   clr_i    in   force speed to 0 (highest priority)
//   inc_i    in   ramp up one step this clock
//   dec_i    in   ramp down one step this clock
//   frwrd_o  out  current forward speed (10 bits)
// -----------------------------------------------------------------------------
module frwrd_ramp #(
   parameter int unsigned FRWRD_INC = 8,
   parameter logic [9:0]  FRWRD_MAX = 10'h300
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       inc_i,
   input  logic       dec_i,
   output logic [9:0] frwrd_o
);

   // One extra bit of headroom so the up-step can be compared against the
   // ceiling before it could wrap.
   localparam logic [10:0] INC_W = 11'(FRWRD_INC);
   localparam logic [10:0] DEC_W = 11'(2 * FRWRD_INC);
   localparam logic [10:0] MAX_W = {1'b0, FRWRD_MAX};

   logic [9:0]  frwrd_q, frwrd_d;
   logic [10:0] q_ext;
   logic [10:0] up_sum;
   logic [10:0] dn_diff;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      q_ext   = {1'b0, frwrd_q};
      up_sum  = q_ext + INC_W;
      dn_diff = q_ext - DEC_W;
      frwrd_d = frwrd_q;
      if (clr_i) begin
         frwrd_d = '0;
      end else if (inc_i) begin
         frwrd_d = (up_sum > MAX_W) ? FRWRD_MAX : up_sum[9:0];
      end else if (dec_i) begin
         frwrd_d = (q_ext < DEC_W) ? 10'h000 : dn_diff[9:0];
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frwrd_q <= '0;
      else        frwrd_q <= frwrd_d;
   end

   assign frwrd_o = frwrd_q;

endmodule

// File: rtl/cmd_exec.sv
// -----------------------------------------------------------------------------
// cmd_exec
// Consumer end of the knight-move command stream. Accepts a 16-bit command from
// the TourCmd/UART mux, acknowledges it, and executes it as a gyro calibration
// or as a heading change followed by a forward move of N squares with a speed
// ramp. A one-cycle send_resp marks completion and advances TourCmd.
//
// Ports:
//   clk                in   system clock
//   rst_n              in   asynchronous active-low reset
//   cmd_i[15:0]        in   [15:12] opcode, [11:4] heading, [3:0] squares
//   cmd_rdy_i          in   command valid, held until cleared
//   clr_cmd_rdy_o      out  acknowledge / consume the command (IDLE only)
//   send_resp_o        out  one-cycle pulse, command finished
//   strt_cal_o         out  one-cycle pulse, start gyro calibration
//   cal_done_i         in   calibration complete
//   heading_settled_i  in   PID heading error within tolerance
//   cntr_ir_i          in   centre line sensor, two lines per square
//   desired_heading_o  out  heading target to PID (12 bits)
//   moving_o           out  PID enable
//   frwrd_o            out  forward speed (10 bits)
//   fanfare_go_o       out  one-cycle pulse at the end of a fanfare move
// -----------------------------------------------------------------------------
module cmd_exec
   import cmd_pkg::*;
#(
   parameter int unsigned FRWRD_INC = 8,
   parameter logic [9:0]  FRWRD_MAX = 10'h300
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cmd_i,
   input  logic        cmd_rdy_i,
   output logic        clr_cmd_rdy_o,
   output logic        send_resp_o,
   output logic        strt_cal_o,
   input  logic        cal_done_i,
   input  logic        heading_settled_i,
   input  logic        cntr_ir_i,
   output logic [11:0] desired_heading_o,
   output logic        moving_o,
   output logic [9:0]  frwrd_o,
   output logic        fanfare_go_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAL,
      S_HEAD,
      S_RAMP_UP,
      S_RAMP_DOWN
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] opc_q, opc_d;          // latched opcode
   logic [3:0] sq_q, sq_d;            // latched square count
   logic [7:0] hdg_q, hdg_d;          // heading of the most recent move
   logic [4:0] cnt_q, cnt_d;          // centre-line edges seen this move
   logic       head_entry_q, head_entry_d;
   logic       cntr_ir_q;
   logic       send_resp_q, send_resp_d;
   logic       strt_cal_q, strt_cal_d;
   logic       fanfare_q, fanfare_d;

   logic       ir_rise;
   logic [4:0] line_target;
   logic       finish;
   logic       ramp_clr, ramp_inc, ramp_dec;
   logic [9:0] frwrd_w;

   // Each square crosses two centre lines.
   assign line_target = {sq_q, 1'b0};
   assign ir_rise     = cntr_ir_i & ~cntr_ir_q;

   frwrd_ramp #(
      .FRWRD_INC (FRWRD_INC),
      .FRWRD_MAX (FRWRD_MAX)
   ) u_ramp (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (ramp_clr),
      .inc_i   (ramp_inc),
      .dec_i   (ramp_dec),
      .frwrd_o (frwrd_w)
   );

   always_comb begin
      state_d       = state_q;
      opc_d         = opc_q;
      sq_d          = sq_q;
      hdg_d         = hdg_q;
      cnt_d         = cnt_q;
      head_entry_d  = 1'b0;
      send_resp_d   = 1'b0;
      strt_cal_d    = 1'b0;
      fanfare_d     = 1'b0;
      clr_cmd_rdy_o = 1'b0;
      moving_o      = 1'b0;
      ramp_clr      = 1'b0;
      ramp_inc      = 1'b0;
      ramp_dec      = 1'b0;
      finish        = 1'b0;

      case (state_q)
         S_IDLE: begin
            clr_cmd_rdy_o = cmd_rdy_i;
            if (cmd_rdy_i) begin
               opc_d = cmd_i[OPC_MSB:OPC_LSB];
               sq_d  = cmd_i[SQ_MSB:SQ_LSB];
               case (cmd_i[OPC_MSB:OPC_LSB])
                  CAL: begin
                     state_d    = S_CAL;
                     strt_cal_d = 1'b1;
                  end
                  MOVE, MOVE_FAN: begin
                     state_d      = S_HEAD;
                     hdg_d        = cmd_i[HDG_MSB:HDG_LSB];
                     head_entry_d = 1'b1;
                  end
                  default: send_resp_d = 1'b1;
               endcase
            end
         end

         S_CAL: begin
            if (cal_done_i) begin
               send_resp_d = 1'b1;
               state_d     = S_IDLE;
            end
         end

         S_HEAD: begin
            moving_o = 1'b1;
            ramp_clr = 1'b1;
            // The PID has not seen the new heading yet on the entry cycle, so
            // a settled flag left over from the previous move is ignored.
            if (!head_entry_q && heading_settled_i) begin
               if (sq_q == 4'h0) begin
                  finish = 1'b1;
               end else begin
                  state_d = S_RAMP_UP;
                  cnt_d   = '0;
               end
            end
         end

         S_RAMP_UP: begin
            moving_o = 1'b1;
            ramp_inc = 1'b1;
            // Once the target is reached the counter stops, so an edge landing
            // in that cycle cannot be counted a second time.
            if (cnt_q == line_target) begin
               state_d = S_RAMP_DOWN;
            end else if (ir_rise) begin
               cnt_d = cnt_q + 5'd1;
            end
         end

         S_RAMP_DOWN: begin
            moving_o = 1'b1;
            if (frwrd_w == 10'h000) finish   = 1'b1;
            else                    ramp_dec = 1'b1;
         end

         default: state_d = S_IDLE;
      endcase

      if (finish) begin
         send_resp_d = 1'b1;
         fanfare_d   = (opc_q == MOVE_FAN);
         state_d     = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         opc_q        <= '0;
         sq_q         <= '0;
         hdg_q        <= '0;
         cnt_q        <= '0;
         head_entry_q <= 1'b0;
         cntr_ir_q    <= 1'b0;
         send_resp_q  <= 1'b0;
         strt_cal_q   <= 1'b0;
         fanfare_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         opc_q        <= opc_d;
         sq_q         <= sq_d;
         hdg_q        <= hdg_d;
         cnt_q        <= cnt_d;
         head_entry_q <= head_entry_d;
         cntr_ir_q    <= cntr_ir_i;
         send_resp_q  <= send_resp_d;
         strt_cal_q   <= strt_cal_d;
         fanfare_q    <= fanfare_d;
      end
   end

   assign send_resp_o       = send_resp_q;
   assign strt_cal_o        = strt_cal_q;
   assign fanfare_go_o      = fanfare_q;
   assign frwrd_o           = frwrd_w;
   assign desired_heading_o = heading_of(hdg_q);

endmodule
